reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/reorder_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: bus widths, depth, opcodes, entry layout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package reorder_buffer_pkg;

    localparam int TAG_W       = 4;
    localparam int REG_W       = 5;
    localparam int XLEN        = 32;
    localparam int ROB_DEPTH   = 15;
    // Dispatch is told to stop two entries early because a request can
    // already be in flight when ROB_FULL rises.
    localparam int FULL_THRESH = 13;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic             busy;
        logic             ready;
        logic             is_load;
        logic             is_store;
        logic             writes_rd;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  npc;
        logic [XLEN-1:0]  alu_output;
        logic [XLEN-1:0]  alu_npc;
        logic [XLEN-1:0]  lmd_output;
    } rob_entry_t;

    // Tags run 1..15; 0 is reserved for "no dependency".
    function automatic tag_t tag_inc(input tag_t t);
        return (t == tag_t'(ROB_DEPTH)) ? tag_t'(1) : t + tag_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: 15-entry circular queue, in-order commit, flush on next-PC mispredict.
// Latency: completion -> commit outputs one cycle after the entry becomes ready; lookups combinational.
// Backpressure: ROB_FULL at occupancy >= 13; dispatches are dropped once all 15 entries are busy; rdy_in low freezes everything.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global enable)
//   dispatch_rdy/up_inst/up_npc/up_rd            : allocate at tail
//   rs_rdy/rs_tag_bus/up_alu_output/alu_npc      : ALU completion
//   lsb_rdy/lsb_tag_bus/up_lmd_output            : load/store completion
//   rs1_rely/rs2_rely -> ROB_rsX_*                : operand lookup
//   ROB_next_tag, head_tag, ROB_FULL, enable_write: queue status
//   commit_pulse/write_rdy/to_rd/write_val/clear/to_pc : registered commit result
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              dispatch_rdy,
    input  logic [XLEN-1:0]   up_inst,
    input  logic [XLEN-1:0]   up_npc,
    input  logic [REG_W-1:0]  up_rd,
    input  logic              rs_rdy,
    input  logic [TAG_W-1:0]  rs_tag_bus,
    input  logic [XLEN-1:0]   up_alu_output,
    input  logic [XLEN-1:0]   alu_npc,
    input  logic              lsb_rdy,
    input  logic [TAG_W-1:0]  lsb_tag_bus,
    input  logic [XLEN-1:0]   up_lmd_output,
    input  logic [TAG_W-1:0]  rs1_rely,
    input  logic [TAG_W-1:0]  rs2_rely,
    output logic              ROB_rs1_valid,
    output logic              ROB_rs1_mem_in_need,
    output logic [XLEN-1:0]   ROB_rs1_alu_output,
    output logic [XLEN-1:0]   ROB_rs1_lmd_output,
    output logic              ROB_rs2_valid,
    output logic              ROB_rs2_mem_in_need,
    output logic [XLEN-1:0]   ROB_rs2_alu_output,
    output logic [XLEN-1:0]   ROB_rs2_lmd_output,
    output logic [TAG_W-1:0]  ROB_next_tag,
    output logic [TAG_W-1:0]  head_tag,
    output logic              write_rdy,
    output logic [REG_W-1:0]  to_rd,
    output logic [XLEN-1:0]   write_val,
    output logic              commit_pulse,
    output logic              clear,
    output logic [XLEN-1:0]   to_pc,
    output logic              enable_write,
    output logic              ROB_FULL
);

    // Slot 0 is never written, so it stays all-zero and a lookup with tag 0
    // naturally reports valid=0 without a special case.
    rob_entry_t rob_q [ROB_DEPTH+1];
    rob_entry_t rob_d [ROB_DEPTH+1];

    tag_t head_q, head_d;
    tag_t tail_q, tail_d;
    tag_t cnt_q,  cnt_d;

    logic             commit_q,    commit_d;
    logic             clear_q,     clear_d;
    logic             write_rdy_q, write_rdy_d;
    logic [REG_W-1:0] to_rd_q,     to_rd_d;
    logic [XLEN-1:0]  write_val_q, write_val_d;
    logic [XLEN-1:0]  to_pc_q,     to_pc_d;

    rob_entry_t hd;
    rob_entry_t ent1;
    rob_entry_t ent2;
    logic       do_commit;
    logic       do_dispatch;
    logic       mem_op;
    logic       mispredict;

    always_comb begin
        rob_d       = rob_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        commit_d    = 1'b0;
        clear_d     = 1'b0;
        write_rdy_d = 1'b0;
        to_rd_d     = to_rd_q;
        write_val_d = write_val_q;
        to_pc_d     = to_pc_q;

        hd          = rob_q[head_q];
        do_commit   = hd.busy && hd.ready;
        mem_op      = hd.is_load || hd.is_store;
        // Loads and stores never redirect; their next PC is the predicted one.
        mispredict  = do_commit && !mem_op && (hd.alu_npc != hd.npc);
        do_dispatch = dispatch_rdy && (cnt_q != tag_t'(ROB_DEPTH));

        if (do_commit) begin
            commit_d    = 1'b1;
            write_rdy_d = hd.writes_rd;
            to_rd_d     = hd.rd;
            write_val_d = hd.is_load ? hd.lmd_output : hd.alu_output;
            to_pc_d     = mem_op ? hd.npc : hd.alu_npc;
            rob_d[head_q].busy = 1'b0;
            head_d      = tag_inc(head_q);
        end

        if (mispredict) begin
            // Everything younger than the branch is wrong-path; drop it along
            // with anything arriving this cycle.
            clear_d = 1'b1;
            for (int i = 0; i <= ROB_DEPTH; i++) begin
                rob_d[i].busy = 1'b0;
            end
            head_d = tag_t'(1);
            tail_d = tag_t'(1);
            cnt_d  = '0;
        end else begin
            if (rs_rdy && (rs_tag_bus != '0)) begin
                rob_d[rs_tag_bus].alu_output = up_alu_output;
                rob_d[rs_tag_bus].alu_npc    = alu_npc;
                rob_d[rs_tag_bus].ready      = 1'b1;
            end
            if (lsb_rdy && (lsb_tag_bus != '0)) begin
                rob_d[lsb_tag_bus].lmd_output = up_lmd_output;
                rob_d[lsb_tag_bus].ready      = 1'b1;
            end
            if (do_dispatch) begin
                rob_d[tail_q].busy       = 1'b1;
                rob_d[tail_q].ready      = 1'b0;
                rob_d[tail_q].inst       = up_inst;
                rob_d[tail_q].npc        = up_npc;
                rob_d[tail_q].rd         = up_rd;
                rob_d[tail_q].is_load    = (up_inst[6:0] == OP_LOAD);
                rob_d[tail_q].is_store   = (up_inst[6:0] == OP_STORE);
                rob_d[tail_q].writes_rd  = (up_inst[6:0] != OP_STORE) &&
                                           (up_inst[6:0] != OP_BRANCH) &&
                                           (up_rd != '0);
                rob_d[tail_q].alu_output = '0;
                rob_d[tail_q].alu_npc    = '0;
                rob_d[tail_q].lmd_output = '0;
                tail_d = tag_inc(tail_q);
            end
            cnt_d = cnt_q + tag_t'(do_dispatch) - tag_t'(do_commit);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i <= ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q      <= tag_t'(1);
            tail_q      <= tag_t'(1);
            cnt_q       <= '0;
            commit_q    <= 1'b0;
            clear_q     <= 1'b0;
            write_rdy_q <= 1'b0;
            to_rd_q     <= '0;
            write_val_q <= '0;
            to_pc_q     <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i <= ROB_DEPTH; i++) begin
                rob_q[i] <= rob_d[i];
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            commit_q    <= commit_d;
            clear_q     <= clear_d;
            write_rdy_q <= write_rdy_d;
            to_rd_q     <= to_rd_d;
            write_val_q <= write_val_d;
            to_pc_q     <= to_pc_d;
        end
    end

    // Operand lookups read state only, never the same-cycle completion buses.
    always_comb begin
        ent1 = rob_q[rs1_rely];
        ent2 = rob_q[rs2_rely];
        ROB_rs1_valid       = ent1.busy && ent1.ready;
        ROB_rs1_mem_in_need = ent1.busy && ent1.is_load;
        ROB_rs1_alu_output  = ent1.alu_output;
        ROB_rs1_lmd_output  = ent1.lmd_output;
        ROB_rs2_valid       = ent2.busy && ent2.ready;
        ROB_rs2_mem_in_need = ent2.busy && ent2.is_load;
        ROB_rs2_alu_output  = ent2.alu_output;
        ROB_rs2_lmd_output  = ent2.lmd_output;
    end

    assign ROB_next_tag = tail_q;
    assign head_tag     = head_q;
    assign ROB_FULL     = (cnt_q >= tag_t'(FULL_THRESH));
    assign enable_write = hd.busy && hd.is_store && !hd.ready;

    assign commit_pulse = commit_q;
    assign clear        = clear_q;
    assign write_rdy    = write_rdy_q;
    assign to_rd        = to_rd_q;
    assign write_val    = write_val_q;
    assign to_pc        = to_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios followed by randomized traffic against a queue model.
// Latency: model predicts registered commit outputs one edge after the head is ready.
// Backpressure: exercises ROB_FULL, dropped dispatch at 15, and rdy_in freezes.
module tb_reorder_buffer;

    logic        clk_in, rst_in, rdy_in;
    logic        dispatch_rdy, rs_rdy, lsb_rdy;
    logic [31:0] up_inst, up_npc, up_alu_output, alu_npc, up_lmd_output;
    logic [4:0]  up_rd;
    logic [3:0]  rs_tag_bus, lsb_tag_bus, rs1_rely, rs2_rely;
    logic        ROB_rs1_valid, ROB_rs1_mem_in_need, ROB_rs2_valid, ROB_rs2_mem_in_need;
    logic [31:0] ROB_rs1_alu_output, ROB_rs1_lmd_output, ROB_rs2_alu_output, ROB_rs2_lmd_output;
    logic [3:0]  ROB_next_tag, head_tag;
    logic        write_rdy, commit_pulse, clear, enable_write, ROB_FULL;
    logic [4:0]  to_rd;
    logic [31:0] write_val, to_pc;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dispatch_rdy(dispatch_rdy), .up_inst(up_inst), .up_npc(up_npc), .up_rd(up_rd),
        .rs_rdy(rs_rdy), .rs_tag_bus(rs_tag_bus), .up_alu_output(up_alu_output), .alu_npc(alu_npc),
        .lsb_rdy(lsb_rdy), .lsb_tag_bus(lsb_tag_bus), .up_lmd_output(up_lmd_output),
        .rs1_rely(rs1_rely), .rs2_rely(rs2_rely),
        .ROB_rs1_valid(ROB_rs1_valid), .ROB_rs1_mem_in_need(ROB_rs1_mem_in_need),
        .ROB_rs1_alu_output(ROB_rs1_alu_output), .ROB_rs1_lmd_output(ROB_rs1_lmd_output),
        .ROB_rs2_valid(ROB_rs2_valid), .ROB_rs2_mem_in_need(ROB_rs2_mem_in_need),
        .ROB_rs2_alu_output(ROB_rs2_alu_output), .ROB_rs2_lmd_output(ROB_rs2_lmd_output),
        .ROB_next_tag(ROB_next_tag), .head_tag(head_tag),
        .write_rdy(write_rdy), .to_rd(to_rd), .write_val(write_val), .commit_pulse(commit_pulse),
        .clear(clear), .to_pc(to_pc), .enable_write(enable_write), .ROB_FULL(ROB_FULL)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    localparam logic [6:0] OPC_ALU = 7'b0010011, OPC_LD = 7'b0000011, OPC_ST = 7'b0100011,
                           OPC_BR  = 7'b1100011, OPC_JAL = 7'b1101111;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: program-order list of live instructions
    typedef struct {
        int          tag;
        logic [31:0] inst, npc, alu, anpc, lmd;
        logic [4:0]  rd;
        bit          ready;
    } m_ent_t;

    m_ent_t      m_q[$];
    int          m_next;
    bit          e_pulse, e_clear, e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_pc;

    function automatic bit op_is(input logic [31:0] inst, input logic [6:0] op);
        return inst[6:0] == op;
    endfunction

    function automatic bit is_mem(input logic [31:0] inst);
        return op_is(inst, OPC_LD) || op_is(inst, OPC_ST);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_next = 1;
        e_pulse = 0; e_clear = 0; e_wr = 0; e_rd = '0; e_val = '0; e_pc = '0;
    endtask

    // stimulus for the next cycle
    logic        en, d_vld, a_vld, l_vld;
    logic [31:0] d_inst, d_npc, a_val, a_npc, l_val;
    logic [4:0]  d_rd;
    logic [3:0]  a_tag, l_tag, r1, r2;

    task automatic model_step();
        int     pre;
        bit     mis;
        m_ent_t h;
        m_ent_t n;
        pre = m_q.size();
        mis = 0;
        e_pulse = 0; e_clear = 0; e_wr = 0;
        if (pre > 0 && m_q[0].ready) begin
            h = m_q[0];
            e_pulse = 1;
            e_rd    = h.rd;
            e_wr    = !op_is(h.inst, OPC_ST) && !op_is(h.inst, OPC_BR) && (h.rd != 0);
            e_val   = op_is(h.inst, OPC_LD) ? h.lmd : h.alu;
            if (is_mem(h.inst)) e_pc = h.npc;
            else begin
                e_pc = h.anpc;
                mis  = (h.anpc != h.npc);
            end
            void'(m_q.pop_front());
        end
        if (mis) begin
            e_clear = 1;
            m_q.delete();
            m_next = 1;
        end else begin
            foreach (m_q[i]) begin
                if (a_vld && m_q[i].tag == int'(a_tag)) begin
                    m_q[i].ready = 1; m_q[i].alu = a_val; m_q[i].anpc = a_npc;
                end
                if (l_vld && m_q[i].tag == int'(l_tag)) begin
                    m_q[i].ready = 1; m_q[i].lmd = l_val;
                end
            end
            if (d_vld && pre < 15) begin
                n.tag = m_next; n.inst = d_inst; n.npc = d_npc; n.rd = d_rd;
                n.alu = '0; n.anpc = '0; n.lmd = '0; n.ready = 0;
                m_q.push_back(n);
                m_next = (m_next % 15) + 1;
            end
        end
    endtask

    task automatic chk_lookup(input string nm, input logic [3:0] t, input logic v, input logic m,
                              input logic [31:0] alu, input logic [31:0] lmd);
        int idx;
        idx = -1;
        foreach (m_q[i]) if (t != 0 && m_q[i].tag == int'(t)) idx = i;
        if (idx < 0) begin
            check({nm, "_valid"}, 32'(v), 0);
            check({nm, "_mem"}, 32'(m), 0);
        end else begin
            check({nm, "_valid"}, 32'(v), 32'(m_q[idx].ready));
            check({nm, "_mem"}, 32'(m), 32'(op_is(m_q[idx].inst, OPC_LD)));
            if (m_q[idx].ready) begin
                check({nm, "_alu"}, alu, m_q[idx].alu);
                check({nm, "_lmd"}, lmd, m_q[idx].lmd);
            end
        end
    endtask

    task automatic check_all();
        bit st_head;
        st_head = (m_q.size() > 0) && op_is(m_q[0].inst, OPC_ST) && !m_q[0].ready;
        check("next_tag", 32'(ROB_next_tag), 32'(m_next));
        check("head_tag", 32'(head_tag), 32'((m_q.size() > 0) ? m_q[0].tag : m_next));
        check("rob_full", 32'(ROB_FULL), 32'(m_q.size() >= 13));
        check("enable_write", 32'(enable_write), 32'(st_head));
        check("commit_pulse", 32'(commit_pulse), 32'(e_pulse));
        check("clear", 32'(clear), 32'(e_clear));
        check("write_rdy", 32'(write_rdy), 32'(e_wr));
        check("to_rd", 32'(to_rd), 32'(e_rd));
        check("write_val", write_val, e_val);
        check("to_pc", to_pc, e_pc);
        chk_lookup("rs1", rs1_rely, ROB_rs1_valid, ROB_rs1_mem_in_need, ROB_rs1_alu_output, ROB_rs1_lmd_output);
        chk_lookup("rs2", rs2_rely, ROB_rs2_valid, ROB_rs2_mem_in_need, ROB_rs2_alu_output, ROB_rs2_lmd_output);
    endtask

    task automatic drive();
        rdy_in = en; dispatch_rdy = d_vld; up_inst = d_inst; up_npc = d_npc; up_rd = d_rd;
        rs_rdy = a_vld; rs_tag_bus = a_tag; up_alu_output = a_val; alu_npc = a_npc;
        lsb_rdy = l_vld; lsb_tag_bus = l_tag; up_lmd_output = l_val;
        rs1_rely = r1; rs2_rely = r2;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle();
        drive();
        #1;
        check_all();
        if (en) model_step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle();
        en = 1; d_vld = 0; a_vld = 0; l_vld = 0; r1 = 0; r2 = 0;
        d_inst = 0; d_npc = 0; d_rd = 0; a_tag = 0; a_val = 0; a_npc = 0; l_tag = 0; l_val = 0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        check("rst_next_tag", 32'(ROB_next_tag), 1);
        check("rst_head_tag", 32'(head_tag), 1);
        check("rst_commit", 32'(commit_pulse), 0);
        check("rst_clear", 32'(clear), 0);
        check("rst_write_rdy", 32'(write_rdy), 0);
        check("rst_to_rd", 32'(to_rd), 0);
        check("rst_write_val", write_val, 0);
        check("rst_to_pc", to_pc, 0);
        check("rst_enable_write", 32'(enable_write), 0);
        check("rst_full", 32'(ROB_FULL), 0);
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [6:0] op);
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], op};
    endfunction

    task automatic dispatch(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] npc);
        d_vld = 1; d_inst = mk_inst(op); d_rd = rd; d_npc = npc;
    endtask

    task automatic gen_random();
        int          ac[$];
        int          lc[$];
        int          k, p;
        logic [6:0]  ops [5];
        ops[0] = OPC_ALU; ops[1] = OPC_LD; ops[2] = OPC_ST; ops[3] = OPC_BR; ops[4] = OPC_JAL;
        idle();
        en = ($urandom_range(0, 9) != 0);
        if (m_q.size() >= 13) d_vld = ($urandom_range(0, 3) == 0);
        else d_vld = ($urandom_range(0, 9) < 6);
        k = $urandom_range(0, 4);
        d_inst = mk_inst(ops[k]);
        d_npc  = $urandom() & 32'hFFFF_FFFC;
        d_rd   = 5'($urandom_range(0, 7));
        foreach (m_q[i]) begin
            if (!m_q[i].ready && !is_mem(m_q[i].inst)) ac.push_back(i);
            if (!m_q[i].ready && is_mem(m_q[i].inst)) lc.push_back(i);
        end
        if (ac.size() > 0 && $urandom_range(0, 1) == 1) begin
            p = ac[$urandom_range(0, ac.size() - 1)];
            a_vld = 1; a_tag = 4'(m_q[p].tag); a_val = $urandom();
            a_npc = m_q[p].npc;
            if (!op_is(m_q[p].inst, OPC_ALU) && $urandom_range(0, 3) == 0)
                a_npc = m_q[p].npc + 32'($urandom_range(1, 64) * 4);
        end
        if (lc.size() > 0 && $urandom_range(0, 1) == 1) begin
            p = lc[$urandom_range(0, lc.size() - 1)];
            l_vld = 1; l_tag = 4'(m_q[p].tag); l_val = $urandom();
        end
        r1 = 4'($urandom_range(0, 15));
        r2 = 4'($urandom_range(0, 15));
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        drive();
        model_reset();
        @(negedge clk_in);
        do_reset();

        // ALU op commits the cycle after its completion
        idle(); dispatch(OPC_ALU, 5, 32'h104); cycle();
        idle(); a_vld = 1; a_tag = 1; a_val = 32'h2A; a_npc = 32'h104; cycle();
        idle(); cycle();
        check("addi_commit", 32'(commit_pulse), 1);
        check("addi_rd", 32'(to_rd), 5);
        check("addi_val", write_val, 32'h2A);
        check("addi_wr", 32'(write_rdy), 1);
        check("addi_clear", 32'(clear), 0);
        idle(); cycle();
        check("addi_pulse_once", 32'(commit_pulse), 0);

        // load: lookup before commit, then commit with loaded data
        do_reset();
        idle(); dispatch(OPC_LD, 3, 32'h200); cycle();
        idle(); l_vld = 1; l_tag = 1; l_val = 32'h1234; cycle();
        idle(); r1 = 1; drive(); #1;
        check("ld_lookup_valid", 32'(ROB_rs1_valid), 1);
        check("ld_lookup_mem", 32'(ROB_rs1_mem_in_need), 1);
        check("ld_lookup_lmd", ROB_rs1_lmd_output, 32'h1234);
        cycle();
        check("ld_val", write_val, 32'h1234);
        check("ld_rd", 32'(to_rd), 3);
        check("ld_pc", to_pc, 32'h200);

        // mispredicted branch flushes younger entries and same-cycle traffic
        do_reset();
        idle(); dispatch(OPC_ALU, 1, 32'h100); cycle();
        idle(); dispatch(OPC_BR, 0, 32'h104); cycle();
        idle(); dispatch(OPC_ALU, 2, 32'h108); a_vld = 1; a_tag = 1; a_val = 7; a_npc = 32'h100; cycle();
        idle(); a_vld = 1; a_tag = 2; a_val = 0; a_npc = 32'h200; r1 = 1; cycle();
        idle(); dispatch(OPC_ALU, 4, 32'h10C); a_vld = 1; a_tag = 3; a_val = 9; a_npc = 32'h108; r1 = 3; cycle();
        check("br_clear", 32'(clear), 1);
        check("br_commit", 32'(commit_pulse), 1);
        check("br_to_pc", to_pc, 32'h200);
        check("br_next_tag", 32'(ROB_next_tag), 1);
        check("br_lookup_gone", 32'(ROB_rs1_valid), 0);
        idle(); cycle();
        check("br_clear_once", 32'(clear), 0);

        // store at head enables the LSB until it completes
        do_reset();
        idle(); dispatch(OPC_ST, 7, 32'h300); cycle();
        idle(); cycle();
        check("st_enable", 32'(enable_write), 1);
        idle(); l_vld = 1; l_tag = 1; l_val = 32'hDEAD; cycle();
        check("st_enable_off", 32'(enable_write), 0);
        idle(); cycle();
        check("st_commit", 32'(commit_pulse), 1);
        check("st_no_wr", 32'(write_rdy), 0);

        // rdy_in low holds a pending completion back
        do_reset();
        idle(); dispatch(OPC_ALU, 9, 32'h400); cycle();
        idle(); en = 0; a_vld = 1; a_tag = 1; a_val = 32'h55; a_npc = 32'h400; cycle(); cycle(); cycle();
        check("frz_no_commit", 32'(commit_pulse), 0);
        check("frz_tag", 32'(ROB_next_tag), 2);
        en = 1; cycle();
        idle(); cycle();
        check("frz_commit_val", write_val, 32'h55);

        // fill: ROB_FULL at 13, tail wraps after 15, 16th dispatch dropped
        do_reset();
        for (int i = 0; i < 13; i++) begin
            idle(); dispatch(OPC_ALU, 1, 32'h500); cycle();
        end
        check("full_13", 32'(ROB_FULL), 1);
        check("full_tag", 32'(ROB_next_tag), 14);
        for (int i = 0; i < 3; i++) begin
            idle(); dispatch(OPC_ALU, 1, 32'h500); cycle();
        end
        check("wrap_tag", 32'(ROB_next_tag), 1);
        check("wrap_head", 32'(head_tag), 1);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (c % 800 == 799) begin
                idle(); drive();
                do_reset();
            end
            gen_random();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
